// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
// Contents:
//   rx_state_t   receiver FSM state encoding
//   PARITY_*     parity mode selectors (none / odd / even)
//   frame_bits() number of sampled bit periods after the start bit
package uart_pkg;

  // Receiver FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Data bits, plus an optional parity bit, plus the stop bits
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line.
// The flops reset to 1 so an idle (high) line never looks like a start bit
// while reset is being released.
// Ports:
//   baud_clk  in   oversampling clock
//   rst_n     in   asynchronous active-low reset
//   async_i   in   asynchronous serial input
//   sync_o    out  synchronised serial line
module uart_rx_sync (
  input  logic baud_clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [1:0] sync_q;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], async_i};
    end
  end

  assign sync_o = sync_q[1];

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser.
// Oversamples the synchronised serial line, rejects false starts, shifts data
// in LSB first, checks parity and stop bits and offers each word on a
// valid/ready handshake. A word completing while the previous one is still
// held is dropped and flagged with a one-cycle overrun pulse.
// Optional build macro:
//   UART_RX_MAJORITY_EN  each bit decision is the 2-of-3 majority of the
//                        synchronised line around the bit centre; every
//                        decision (and thus rx_valid/overrun) lands one
//                        cycle later than in the single-sample build.
// Ports:
//   baud_clk    in   oversampling clock (OVERSAMPLE cycles per bit)
//   rst_n       in   asynchronous active-low reset
//   rx_in       in   raw serial line, idle high
//   rx_data     out  received word, valid while rx_valid
//   rx_valid    out  word available
//   rx_ready    in   consumer accepts word
//   parity_err  out  parity mismatch on the held word
//   frame_err   out  a stop bit was sampled low on the held word
//   overrun     out  one-cycle pulse when a completed frame is dropped
//   busy        out  receiver is not idle
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PARITY_NONE,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int NBITS = frame_bits(DATA_BITS, PARITY, STOP_BITS);
  localparam int CW    = $clog2(OVERSAMPLE) + 1;
  localparam int BW    = $clog2(NBITS + 1);

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC_DELAY = 1;
`else
  localparam int DEC_DELAY = 0;
`endif

  // The start decision sits half a bit in; every later decision one full bit on
  localparam logic [CW-1:0] START_DEC = CW'(OVERSAMPLE / 2 - 1 + DEC_DELAY);
  localparam logic [CW-1:0] BIT_DEC   = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);

  logic                 rxs;
  logic                 bitVal_d;
  logic                 frameDone_d;
  logic                 perr_d;
  logic                 ferr_d;
  logic                 parExp_d;

  rx_state_t            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bitCnt_q;
  logic [DATA_BITS-1:0] shiftReg_q;
  logic                 stopErr_q;
  logic                 parErr_q;
  logic [DATA_BITS-1:0] rxData_q;
  logic                 rxValid_q;
  logic                 parityErr_q;
  logic                 frameErr_q;
  logic                 overrun_q;

  uart_rx_sync u_sync (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .async_i  (rx_in),
    .sync_o   (rxs)
  );

`ifdef UART_RX_MAJORITY_EN
  // The two previous synchronised samples; with the current one they form
  // the three-sample window ending on the decision edge
  logic [1:0] hist_q;

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxs};
    end
  end

  assign bitVal_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs) | (hist_q[0] & rxs);
`else
  assign bitVal_d = rxs;
`endif

  // Frame completion and the flags that go with the word being completed
  always_comb begin
    frameDone_d = (state_q == ST_STOP) && (cnt_q == BIT_DEC) && (bitCnt_q == LAST_BIT);
    ferr_d      = stopErr_q | ~bitVal_d;
    perr_d      = (PARITY != PARITY_NONE) && parErr_q;
    parExp_d    = (^shiftReg_q) ^ (PARITY == PARITY_ODD);
  end

  // Receiver FSM plus the output holding register and handshake
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitCnt_q    <= '0;
      shiftReg_q  <= '0;
      stopErr_q   <= 1'b0;
      parErr_q    <= 1'b0;
      rxData_q    <= '0;
      rxValid_q   <= 1'b0;
      parityErr_q <= 1'b0;
      frameErr_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= 1'b0;

      // A word still held and not being taken on this edge blocks the new one
      if (frameDone_d) begin
        if (rxValid_q && !rx_ready) begin
          overrun_q <= 1'b1;
        end else begin
          rxData_q    <= shiftReg_q;
          parityErr_q <= perr_d;
          frameErr_q  <= ferr_d;
          rxValid_q   <= 1'b1;
        end
      end else if (rxValid_q && rx_ready) begin
        rxValid_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_q <= ST_START;
            cnt_q   <= '0;
          end
        end
        ST_START: begin
          if (cnt_q == START_DEC) begin
            cnt_q     <= '0;
            bitCnt_q  <= '0;
            stopErr_q <= 1'b0;
            parErr_q  <= 1'b0;
            state_q   <= bitVal_d ? ST_IDLE : ST_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == BIT_DEC) begin
            cnt_q      <= '0;
            bitCnt_q   <= bitCnt_q + BW'(1);
            shiftReg_q <= {bitVal_d, shiftReg_q[DATA_BITS-1:1]};
            if (bitCnt_q == LAST_DATA) begin
              state_q <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_PARITY: begin
          if (cnt_q == BIT_DEC) begin
            cnt_q    <= '0;
            bitCnt_q <= bitCnt_q + BW'(1);
            parErr_q <= (bitVal_d != parExp_d);
            state_q  <= ST_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_STOP: begin
          if (cnt_q == BIT_DEC) begin
            cnt_q     <= '0;
            bitCnt_q  <= bitCnt_q + BW'(1);
            stopErr_q <= ferr_d;
            // A low final stop bit means the line may be held low; wait it out
            if (bitCnt_q == LAST_BIT) begin
              state_q <= bitVal_d ? ST_IDLE : ST_BREAK;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_BREAK: begin
          if (rxs) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_data    = rxData_q;
  assign rx_valid   = rxValid_q;
  assign parity_err = parityErr_q;
  assign frame_err  = frameErr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser.
// Three instances share clock and reset: 8N1, 8E1 and 8N2, all at 16x.
// Frames are driven cycle by cycle from a list of bit levels; a monitor
// records every accepted word, and each test compares those records with
// values worked out from the frame contents and the frame timing rules.
module tb_uart_rx_deser;

  localparam int OS = 16;
`ifdef UART_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  // Edges from the first start-bit edge k to the completing edge
  localparam int LAT9  = 2 + OS / 2 + 9 * OS + MAJ;
  localparam int LAT10 = 2 + OS / 2 + 10 * OS + MAJ;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         at;
  } rec_t;

  logic       baud_clk;
  logic       rst_n;
  int         cyc;

  logic       rxA, rdyA, vA, peA, feA, ovA_o, busyA;
  logic [7:0] dataA;
  logic       rxE, rdyE, vE, peE, feE, ovE_o, busyE;
  logic [7:0] dataE;
  logic       rxC, rdyC, vC, peC, feC, ovC_o, busyC;
  logic [7:0] dataC;

  rec_t gotA[$];
  rec_t gotE[$];
  rec_t gotC[$];
  int   ovA, ovE, ovC;
  int   checks, fails;

  uart_rx_deser #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(OS)) dut_a (
    .baud_clk(baud_clk), .rst_n(rst_n), .rx_in(rxA), .rx_data(dataA), .rx_valid(vA),
    .rx_ready(rdyA), .parity_err(peA), .frame_err(feA), .overrun(ovA_o), .busy(busyA));

  uart_rx_deser #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(OS)) dut_e (
    .baud_clk(baud_clk), .rst_n(rst_n), .rx_in(rxE), .rx_data(dataE), .rx_valid(vE),
    .rx_ready(rdyE), .parity_err(peE), .frame_err(feE), .overrun(ovE_o), .busy(busyE));

  uart_rx_deser #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .OVERSAMPLE(OS)) dut_c (
    .baud_clk(baud_clk), .rst_n(rst_n), .rx_in(rxC), .rx_data(dataC), .rx_valid(vC),
    .rx_ready(rdyC), .parity_err(peC), .frame_err(feC), .overrun(ovC_o), .busy(busyC));

  // Clock; cyc holds the number of the most recent rising edge
  initial begin
    baud_clk = 1'b0;
    cyc      = 0;
    forever begin
      #5 baud_clk = 1'b1;
      cyc = cyc + 1;
      #5 baud_clk = 1'b0;
    end
  end

  // Record every word taken by the consumer and every overrun pulse
  always @(negedge baud_clk) begin
    if (vA && rdyA) gotA.push_back('{d: dataA, pe: peA, fe: feA, at: cyc});
    if (vE && rdyE) gotE.push_back('{d: dataE, pe: peE, fe: feE, at: cyc});
    if (vC && rdyC) gotC.push_back('{d: dataC, pe: peC, fe: feC, at: cyc});
    if (ovA_o) ovA++;
    if (ovE_o) ovE++;
    if (ovC_o) ovC++;
  end

  // Safety net against a stuck run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8e1(input logic [7:0] d, input logic p);
    return {5'b0, 1'b1, p, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8n2(input logic [7:0] d, input logic s1, input logic s2);
    return {5'b0, s2, s1, d, 1'b0};
  endfunction

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rxA = v;
      1:       rxE = v;
      default: rxC = v;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  task automatic at_negedge_of(input int target);
    @(negedge baud_clk);
    while (cyc < target) @(negedge baud_clk);
  endtask

  // Drives nb bit periods from lv (lv[0] first); one cycle may be inverted.
  // k is the first edge that sees the start bit on rx_in.
  task automatic send_frame(input int which, input logic [15:0] lv, input int nb,
                            input int glitch_j, output int k);
    k = cyc + 1;
    for (int j = 0; j < nb * OS; j++) begin
      logic b;
      b = lv[j / OS];
      if (j == glitch_j) b = ~b;
      set_rx(which, b);
      @(posedge baud_clk);
      #1;
    end
    set_rx(which, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxA = 1'b1; rxE = 1'b1; rxC = 1'b1;
    rdyA = 1'b0; rdyE = 1'b0; rdyC = 1'b0;
    @(negedge baud_clk);
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b want 0", vA); end
    checks++; if (dataA !== 8'h00) begin fails++; $display("[TB] FAIL reset_data: got %h want 00", dataA); end
    checks++; if (peA !== 1'b0) begin fails++; $display("[TB] FAIL reset_perr: got %b want 0", peA); end
    checks++; if (feA !== 1'b0) begin fails++; $display("[TB] FAIL reset_ferr: got %b want 0", feA); end
    checks++; if (ovA_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun: got %b want 0", ovA_o); end
    checks++; if (busyA !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busyA); end
    checks++; if (vE !== 1'b0 || vC !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid_other: got %b%b want 00", vE, vC); end
    @(posedge baud_clk);
    #1 rst_n = 1'b1;
    idle(4);
    checks++; if (busyA !== 1'b0 || busyE !== 1'b0 || busyC !== 1'b0) begin
      fails++; $display("[TB] FAIL idle_busy: got %b%b%b want 000", busyA, busyE, busyC);
    end
  endtask

  task automatic test_basic();
    int k;
    rdyA = 1'b1;
    gotA.delete();
    send_frame(0, f8n1(8'hA5, 1'b1), 10, -1, k);
    idle(20);
    checks++; if (gotA.size() !== 1) begin fails++; $display("[TB] FAIL basic_count: got %0d want 1", gotA.size()); end
    if (gotA.size() > 0) begin
      checks++; if (gotA[0].d !== 8'hA5) begin fails++; $display("[TB] FAIL basic_data: got %h want a5", gotA[0].d); end
      checks++; if (gotA[0].pe !== 1'b0 || gotA[0].fe !== 1'b0) begin
        fails++; $display("[TB] FAIL basic_errs: got pe=%b fe=%b want 0 0", gotA[0].pe, gotA[0].fe);
      end
      checks++; if (gotA[0].at !== k + LAT9) begin fails++; $display("[TB] FAIL basic_latency: got %0d want %0d", gotA[0].at, k + LAT9); end
    end
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL basic_valid_drop: got %b want 0", vA); end
  endtask

  task automatic test_random();
    logic [7:0] expD[$];
    logic       expF[$];
    int         expAt[$];
    int         k;
    rdyA = 1'b1;
    gotA.delete();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      logic       s;
      d = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(0, f8n1(d, s), 10, -1, k);
      expD.push_back(d);
      expF.push_back(~s);
      expAt.push_back(k + LAT9);
      idle(2 * OS);
    end
    checks++; if (gotA.size() !== 8) begin fails++; $display("[TB] FAIL random_count: got %0d want 8", gotA.size()); end
    for (int i = 0; i < 8 && i < gotA.size(); i++) begin
      checks++; if (gotA[i].d !== expD[i]) begin fails++; $display("[TB] FAIL random_data[%0d]: got %h want %h", i, gotA[i].d, expD[i]); end
      checks++; if (gotA[i].fe !== expF[i]) begin fails++; $display("[TB] FAIL random_ferr[%0d]: got %b want %b", i, gotA[i].fe, expF[i]); end
      checks++; if (gotA[i].pe !== 1'b0) begin fails++; $display("[TB] FAIL random_perr[%0d]: got %b want 0", i, gotA[i].pe); end
      checks++; if (gotA[i].at !== expAt[i]) begin fails++; $display("[TB] FAIL random_time[%0d]: got %0d want %0d", i, gotA[i].at, expAt[i]); end
    end
  endtask

  task automatic test_false_start();
    int k;
    int e;
    rdyA = 1'b1;
    gotA.delete();
    k = cyc + 1;
    rxA = 1'b0;
    idle(6);
    rxA = 1'b1;
    e = k + 2;
    at_negedge_of(e + 7 + MAJ);
    checks++; if (busyA !== 1'b1) begin fails++; $display("[TB] FAIL false_start_busy_hi: got %b want 1", busyA); end
    at_negedge_of(e + 8 + MAJ);
    checks++; if (busyA !== 1'b0) begin fails++; $display("[TB] FAIL false_start_busy_lo: got %b want 0", busyA); end
    idle(200);
    checks++; if (gotA.size() !== 0) begin fails++; $display("[TB] FAIL false_start_words: got %0d want 0", gotA.size()); end
  endtask

  task automatic test_parity();
    logic [7:0] expD[$];
    logic       expP[$];
    int         k;
    rdyE = 1'b1;
    gotE.delete();
    for (int i = 0; i < 6; i++) begin
      logic [7:0] d;
      logic       p;
      d = (i == 0) ? 8'h03 : 8'($urandom);
      p = (i == 0) ? 1'b1 : 1'($urandom);
      send_frame(1, f8e1(d, p), 11, -1, k);
      expD.push_back(d);
      // Even parity: data ones plus the parity bit must total an even count
      expP.push_back((($countones(d) + int'(p)) % 2) != 0);
      idle(OS);
    end
    checks++; if (gotE.size() !== 6) begin fails++; $display("[TB] FAIL parity_count: got %0d want 6", gotE.size()); end
    for (int i = 0; i < 6 && i < gotE.size(); i++) begin
      checks++; if (gotE[i].d !== expD[i]) begin fails++; $display("[TB] FAIL parity_data[%0d]: got %h want %h", i, gotE[i].d, expD[i]); end
      checks++; if (gotE[i].pe !== expP[i]) begin fails++; $display("[TB] FAIL parity_err[%0d]: got %b want %b", i, gotE[i].pe, expP[i]); end
      checks++; if (gotE[i].fe !== 1'b0) begin fails++; $display("[TB] FAIL parity_ferr[%0d]: got %b want 0", i, gotE[i].fe); end
    end
  endtask

  task automatic test_break();
    int k;
    int k2;
    rdyC = 1'b1;
    gotC.delete();
    send_frame(2, f8n2(8'h6C, 1'b1, 1'b0), 11, -1, k);
    rxC = 1'b0;
    idle(20 * OS);
    checks++; if (busyC !== 1'b1) begin fails++; $display("[TB] FAIL break_busy: got %b want 1", busyC); end
    idle(20 * OS);
    rxC = 1'b1;
    idle(2 * OS);
    checks++; if (busyC !== 1'b0) begin fails++; $display("[TB] FAIL break_exit: got %b want 0", busyC); end
    send_frame(2, f8n2(8'h3E, 1'b1, 1'b1), 11, -1, k2);
    idle(2 * OS);
    checks++; if (gotC.size() !== 2) begin fails++; $display("[TB] FAIL break_count: got %0d want 2", gotC.size()); end
    if (gotC.size() > 1) begin
      checks++; if (gotC[0].d !== 8'h6C || gotC[0].fe !== 1'b1) begin
        fails++; $display("[TB] FAIL break_word: got %h fe=%b want 6c fe=1", gotC[0].d, gotC[0].fe);
      end
      checks++; if (gotC[0].at !== k + LAT10) begin fails++; $display("[TB] FAIL break_time: got %0d want %0d", gotC[0].at, k + LAT10); end
      checks++; if (gotC[1].d !== 8'h3E || gotC[1].fe !== 1'b0) begin
        fails++; $display("[TB] FAIL break_next: got %h fe=%b want 3e fe=0", gotC[1].d, gotC[1].fe);
      end
    end
  endtask

  task automatic test_overrun();
    int k1;
    int k2;
    int k2pre;
    // Consumer stalled: second word is dropped
    rdyA = 1'b0;
    gotA.delete();
    ovA = 0;
    send_frame(0, f8n1(8'h11, 1'b1), 10, -1, k1);
    send_frame(0, f8n1(8'h22, 1'b1), 10, -1, k2);
    idle(4);
    checks++; if (vA !== 1'b1 || dataA !== 8'h11) begin fails++; $display("[TB] FAIL overrun_hold: got v=%b %h want v=1 11", vA, dataA); end
    checks++; if (ovA !== 1) begin fails++; $display("[TB] FAIL overrun_pulses: got %0d want 1", ovA); end
    rdyA = 1'b1;
    idle(3);
    rdyA = 1'b0;
    checks++; if (gotA.size() !== 1) begin fails++; $display("[TB] FAIL overrun_drain: got %0d want 1", gotA.size()); end
    checks++; if (vA !== 1'b0) begin fails++; $display("[TB] FAIL overrun_empty: got %b want 0", vA); end

    // Consumer takes the old word on the very edge the new one completes
    gotA.delete();
    ovA = 0;
    send_frame(0, f8n1(8'h11, 1'b1), 10, -1, k1);
    k2pre = cyc + 1;
    fork
      send_frame(0, f8n1(8'h22, 1'b1), 10, -1, k2);
      begin
        while (cyc < k2pre + LAT9 - 1) @(posedge baud_clk);
        #1 rdyA = 1'b1;
        at_negedge_of(k2pre + LAT9);
        checks++; if (vA !== 1'b1 || dataA !== 8'h22) begin fails++; $display("[TB] FAIL swap_load: got v=%b %h want v=1 22", vA, dataA); end
      end
    join
    idle(4);
    rdyA = 1'b0;
    checks++; if (ovA !== 0) begin fails++; $display("[TB] FAIL swap_overrun: got %0d want 0", ovA); end
    checks++; if (gotA.size() !== 2) begin fails++; $display("[TB] FAIL swap_count: got %0d want 2", gotA.size()); end
    if (gotA.size() > 1) begin
      checks++; if (gotA[0].d !== 8'h11 || gotA[1].d !== 8'h22) begin
        fails++; $display("[TB] FAIL swap_order: got %h %h want 11 22", gotA[0].d, gotA[1].d);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    rdyA = 1'b0;
    send_frame(0, f8n1(8'h33, 1'b1), 10, -1, k);
    idle(4);
    rxA = 1'b0;
    idle(3 * OS);
    checks++; if (vA !== 1'b1 || busyA !== 1'b1) begin fails++; $display("[TB] FAIL pre_reset: got v=%b busy=%b want 1 1", vA, busyA); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (vA !== 1'b0 || dataA !== 8'h00 || busyA !== 1'b0 || peA !== 1'b0 || feA !== 1'b0 || ovA_o !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_reset_outputs: got v=%b d=%h busy=%b pe=%b fe=%b ov=%b want all 0", vA, dataA, busyA, peA, feA, ovA_o);
    end
    rxA = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(4);
    rdyA = 1'b1;
    gotA.delete();
    send_frame(0, f8n1(8'h5A, 1'b1), 10, -1, k);
    idle(20);
    checks++; if (gotA.size() !== 1) begin fails++; $display("[TB] FAIL after_reset_count: got %0d want 1", gotA.size()); end
    if (gotA.size() > 0) begin
      checks++; if (gotA[0].d !== 8'h5A) begin fails++; $display("[TB] FAIL after_reset_data: got %h want 5a", gotA[0].d); end
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  task automatic test_majority();
    int k;
    rdyA = 1'b1;
    gotA.delete();
    // Invert the line for one cycle right at the centre of data bit 0, then bit 3
    send_frame(0, f8n1(8'h00, 1'b1), 10, 25, k);
    idle(OS);
    send_frame(0, f8n1(8'hFF, 1'b1), 10, 25 + 3 * OS, k);
    idle(OS);
    checks++; if (gotA.size() !== 2) begin fails++; $display("[TB] FAIL majority_count: got %0d want 2", gotA.size()); end
    if (gotA.size() > 1) begin
      checks++; if (gotA[0].d !== 8'h00) begin fails++; $display("[TB] FAIL majority_zero: got %h want 00", gotA[0].d); end
      checks++; if (gotA[1].d !== 8'hFF) begin fails++; $display("[TB] FAIL majority_one: got %h want ff", gotA[1].d); end
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    ovA = 0; ovE = 0; ovC = 0;
    test_reset();
    test_basic();
    test_random();
    test_false_start();
    test_parity();
    test_break();
    test_overrun();
    test_reset_mid();
`ifdef UART_RX_MAJORITY_EN
    test_majority();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
